// File: rtl/mem_dma_master_pkg.sv
// Shared state encodings, mode constants and default widths for the block-copy/fill engine.
package mem_dma_master_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 8;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_t;

endpackage

// File: rtl/mem_dma_master.sv
// Memory-port DMA initiator: copies or fills N words, one start pulse per transfer.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; parameters latched on start
// RD      | copy only: read src_ptr, capture word into data register
// WR      | write dst_ptr, advance pointers and word counter
// DONE    | one-cycle done pulse, then back to IDLE
module mem_dma_master
  import mem_dma_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  dma_state_t        r_state;
  logic              r_mode;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_fill;

  logic [LEN_W-1:0]  w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_COPY;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_fill  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_src  <= src_addr;
            r_dst  <= dst_addr;
            r_len  <= len;
            r_fill <= fill_data;
            r_cnt  <= '0;
            if (len == '0)             r_state <= ST_DONE;
            else if (mode == MODE_COPY) r_state <= ST_RD;
            else                        r_state <= ST_WR;
          end
        end
        ST_RD: begin
          r_data  <= mem_read_data;
          r_state <= ST_WR;
        end
        ST_WR: begin
          r_src <= r_src + ADDR_W'(1);
          r_dst <= r_dst + ADDR_W'(1);
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == r_len)       r_state <= ST_DONE;
          else if (r_mode == MODE_COPY) r_state <= ST_RD;
          else                          r_state <= ST_WR;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Port outputs decode registered state only; read data never reaches them combinationally.
  assign busy            = (r_state != ST_IDLE);
  assign done            = (r_state == ST_DONE);
  assign mem_read        = (r_state == ST_RD);
  assign mem_write_en    = (r_state == ST_WR);
  assign mem_access_addr = (r_state == ST_RD) ? r_src :
                           (r_state == ST_WR) ? r_dst : '0;
  assign mem_write_data  = (r_state != ST_WR)     ? '0     :
                           (r_mode == MODE_FILL)  ? r_fill : r_data;

endmodule

// File: tb/tb_mem_dma_master.sv
// Self-checking bench for mem_dma_master: directed scenarios plus randomized transfers vs a word-level model.
module tb_mem_dma_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  len;
  logic [15:0] fill_data;
  logic        busy;
  logic        done;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  logic [15:0] mem [0:65535];
  logic [15:0] mm  [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  int n_checks;
  int n_fail;

  mem_dma_master dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .mode            (mode),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .len             (len),
    .fill_data       (fill_data),
    .busy            (busy),
    .done            (done),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write_en) mem[mem_access_addr] <= mem_write_data;
  end
  assign mem_read_data = mem[mem_access_addr];

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    mm[a] = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Per-cycle expectation {busy, done, read, write, addr, wdata} built from the
  // transfer rules: copy = read word then write word, fill = write each word.
  task automatic run_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] n, input logic [15:0] f, input int restart_cyc);
    logic [35:0] q[$];
    logic [35:0] obs;
    logic [15:0] a_s, a_d, w;
    q.delete();
    for (int i = 0; i < int'(n); i++) begin
      a_s = s + 16'(i);
      a_d = d + 16'(i);
      if (m == 1'b0) begin
        w = mm[a_s];
        q.push_back({1'b1, 1'b0, 1'b1, 1'b0, a_s, 16'h0});
      end else begin
        w = f;
      end
      q.push_back({1'b1, 1'b0, 1'b0, 1'b1, a_d, w});
      mm[a_d] = w;
    end
    q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0});
    q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});

    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n; fill_data = f;
    @(posedge clk);
    for (int c = 1; c <= q.size(); c++) begin
      @(negedge clk);
      start = 1'b0;
      mode = 1'($urandom); src_addr = 16'($urandom); dst_addr = 16'($urandom);
      len = 8'($urandom); fill_data = 16'($urandom);
      obs = {busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data};
      n_checks++;
      if (obs !== q[c-1]) begin
        n_fail++;
        $display("FAIL xfer_cycle%0d mode=%0d len=%0d got {busy,done,rd,wr,addr,wd}=%h want %h",
                 c, m, n, obs, q[c-1]);
      end
      if (c == restart_cyc && c < q.size()) begin
        start = 1'b1; dst_addr = d ^ 16'h0100; len = 8'd3; mode = m;
      end
    end
    start = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      a_d = d + 16'(i);
      n_checks++;
      if (mem[a_d] !== mm[a_d]) begin
        n_fail++;
        $display("FAIL xfer_mem addr=%h got %h want %h", a_d, mem[a_d], mm[a_d]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b wr=%b addr=%h wd=%h want all 0",
               busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_copy;
    preload(16'h0000, 16'h1111);
    preload(16'h0001, 16'h2222);
    preload(16'h0002, 16'h3333);
    run_xfer(1'b0, 16'h0000, 16'h0004, 8'd3, 16'h0, 0);
    n_checks++;
    if ({mem[4], mem[5], mem[6]} !== 48'h1111_2222_3333) begin
      n_fail++;
      $display("FAIL copy_dest got %h %h %h want 1111 2222 3333", mem[4], mem[5], mem[6]);
    end
  endtask

  task automatic test_fill;
    run_xfer(1'b1, 16'h0000, 16'h0002, 8'd4, 16'hA5A5, 0);
    n_checks++;
    if ({mem[2], mem[3], mem[4], mem[5]} !== {4{16'hA5A5}}) begin
      n_fail++;
      $display("FAIL fill_dest got %h %h %h %h want a5a5 x4", mem[2], mem[3], mem[4], mem[5]);
    end
  endtask

  task automatic test_len_zero;
    run_xfer(1'b0, 16'h0010, 16'h0020, 8'd0, 16'h0, 0);
    run_xfer(1'b1, 16'h0010, 16'h0020, 8'd0, 16'hFFFF, 0);
  endtask

  task automatic test_start_while_busy;
    for (int i = 0; i < 3; i++) preload(16'h0030 + 16'(i), 16'($urandom));
    preload(16'h0140, 16'hBEEF);
    run_xfer(1'b0, 16'h0030, 16'h0040, 8'd3, 16'h0, 3);
    n_checks++;
    if (mem[16'h0140] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL busy_restart_dest got %h want beef", mem[16'h0140]);
    end
  endtask

  task automatic test_wrap;
    run_xfer(1'b1, 16'h0000, 16'hFFFE, 8'd3, 16'h5A5A, 0);
    n_checks++;
    if ({mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]} !== {3{16'h5A5A}}) begin
      n_fail++;
      $display("FAIL wrap_dest got %h %h %h want 5a5a x3",
               mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]);
    end
  endtask

  task automatic test_reset_mid_op;
    for (int i = 0; i < 3; i++) begin
      preload(16'h0050 + 16'(i), 16'h0C00 + 16'(i));
      preload(16'h0080 + 16'(i), 16'hDEAD);
    end
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src_addr = 16'h0050; dst_addr = 16'h0080; len = 8'd3;
    @(posedge clk);
    repeat (4) @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (mem_write_en !== 1'b1 || mem_access_addr !== 16'h0081) begin
      n_fail++;
      $display("FAIL rst_mid_pre got wr=%b addr=%h want 1 0081", mem_write_en, mem_access_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data} !== 36'h0) begin
      n_fail++;
      $display("FAIL rst_mid_strobes got busy=%b done=%b rd=%b wr=%b addr=%h wd=%h want all 0",
               busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data);
    end
    mm[16'h0080] = 16'h0C00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_hold got done=%b busy=%b want 0 0", done, busy);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem[16'h0080 + 16'(i)] !== mm[16'h0080 + 16'(i)]) begin
        n_fail++;
        $display("FAIL rst_mid_mem addr=%h got %h want %h", 16'h0080 + 16'(i),
                 mem[16'h0080 + 16'(i)], mm[16'h0080 + 16'(i)]);
      end
    end
    run_xfer(1'b0, 16'h0050, 16'h0090, 8'd3, 16'h0, 0);
  endtask

  task automatic test_random;
    logic        m;
    logic [7:0]  n;
    logic [15:0] s, d, f;
    for (int k = 0; k < 10; k++) begin
      m = 1'($urandom);
      n = 8'($urandom_range(0, 12));
      s = 16'($urandom);
      d = 16'($urandom);
      f = 16'($urandom);
      if (m == 1'b0)
        for (int i = 0; i < int'(n); i++) preload(s + 16'(i), 16'($urandom));
      run_xfer(m, s, d, n, f, int'($urandom_range(0, 3)));
    end
    // overlapping forward copy: ascending order propagates the first words
    for (int i = 0; i < 6; i++) preload(16'h0200 + 16'(i), 16'h7000 + 16'(i));
    run_xfer(1'b0, 16'h0200, 16'h0202, 8'd4, 16'h0, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    rst_n = 1'b1;
    test_reset();
    test_copy();
    test_fill();
    test_len_zero();
    test_start_while_busy();
    test_wrap();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
